// File: rtl/time_pkg.sv
// Shared types and constants for the stopwatch/timer time-entry block.
package time_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT,
    CONV_MIN,
    CONV_SEC,
    CONV_CS
  } state_t;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int CURSOR_W   = 3;
  localparam int MIN_W      = 6;
  localparam int SEC_W      = 6;
  localparam int CS_W       = 7;
  localparam int BIN_W      = 7;

  localparam logic [DIGIT_W-1:0]  BLANK_CODE  = 4'd10;
  localparam logic [DIGIT_W-1:0]  TENS_LIMIT  = 4'd5;
  localparam logic [DIGIT_W-1:0]  ONES_LIMIT  = 4'd9;
  localparam logic [CURSOR_W-1:0] LAST_DIGIT  = 3'd5;

  // Minute tens and second tens stop at 5; every other position is a full decimal digit.
  function automatic logic [DIGIT_W-1:0] digit_limit(input logic [CURSOR_W-1:0] idx);
    return ((idx == 3'd0) || (idx == 3'd2)) ? TENS_LIMIT : ONES_LIMIT;
  endfunction

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Converts a tens/ones decimal digit pair into a 7-bit binary value (0-99).
module bcd_pair_to_bin
  import time_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] ones,
  output logic [BIN_W-1:0]   bin
);

  logic [BIN_W-1:0] tens_w;
  logic [BIN_W-1:0] ones_w;

  assign tens_w = {{(BIN_W-DIGIT_W){1'b0}}, tens};
  assign ones_w = {{(BIN_W-DIGIT_W){1'b0}}, ones};

  // tens*10 as tens*8 + tens*2; 9*10+9 = 99 still fits in 7 bits.
  assign bin = (tens_w << 3) + (tens_w << 1) + ones_w;

endmodule

// File: rtl/time_digit_entry.sv
// Six-digit mm:ss.cc entry with blinking cursor; converts the digits to binary
// one field per cycle through a single shared BCD-pair converter.
module time_digit_entry #(
  parameter int unsigned BLINK_HALF = 50,
  parameter logic [3:0]  BLANK_CODE = time_pkg::BLANK_CODE
) (
  input  logic       mili_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_commit,
  output logic [3:0] bch0,
  output logic [3:0] bch1,
  output logic [3:0] bch2,
  output logic [3:0] bch3,
  output logic [3:0] bch4,
  output logic [3:0] bch5,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic [6:0] set_m_seconds,
  output logic       set_valid,
  output logic       editing
);

  import time_pkg::*;

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  state_t                                 state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     digits_q, digits_d;
  logic [CURSOR_W-1:0]                    cursor_q, cursor_d;
  logic [CNT_W-1:0]                       blink_cnt_q, blink_cnt_d;
  logic                                   blink_on_q, blink_on_d;
  logic [MIN_W-1:0]                       set_minutes_q, set_minutes_d;
  logic [SEC_W-1:0]                       set_seconds_q, set_seconds_d;
  logic [CS_W-1:0]                        set_m_seconds_q, set_m_seconds_d;
  logic                                   set_valid_q, set_valid_d;
  logic                                   editing_q, editing_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     bch_q, bch_d;

  logic [DIGIT_W-1:0] conv_tens;
  logic [DIGIT_W-1:0] conv_ones;
  logic [BIN_W-1:0]   conv_bin;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] cur_limit;

  assign cur_digit = digits_q[cursor_q];
  assign cur_limit = digit_limit(cursor_q);

  // The conversion state selects which digit pair feeds the shared converter.
  always_comb begin
    conv_tens = digits_q[0];
    conv_ones = digits_q[1];
    case (state_q)
      CONV_SEC: begin
        conv_tens = digits_q[2];
        conv_ones = digits_q[3];
      end
      CONV_CS: begin
        conv_tens = digits_q[4];
        conv_ones = digits_q[5];
      end
      default: ;
    endcase
  end

  bcd_pair_to_bin u_conv (
    .tens (conv_tens),
    .ones (conv_ones),
    .bin  (conv_bin)
  );

  always_comb begin
    state_d         = state_q;
    digits_d        = digits_q;
    cursor_d        = cursor_q;
    blink_cnt_d     = blink_cnt_q;
    blink_on_d      = blink_on_q;
    set_minutes_d   = set_minutes_q;
    set_seconds_d   = set_seconds_q;
    set_m_seconds_d = set_m_seconds_q;
    set_valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (enable) begin
          state_d  = EDIT;
          digits_d = '0;
          cursor_d = '0;
        end
      end

      // Only one button action per cycle; every action restarts the blink "on" phase.
      EDIT: begin
        if (!enable) begin
          state_d     = IDLE;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else if (btn_commit || btn_next || btn_inc || btn_dec) begin
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
          if (btn_commit) begin
            state_d = CONV_MIN;
          end else if (btn_next) begin
            cursor_d = (cursor_q == LAST_DIGIT) ? '0 : cursor_q + 3'd1;
          end else if (btn_inc) begin
            digits_d[cursor_q] = (cur_digit >= cur_limit) ? '0 : cur_digit + 4'd1;
          end else begin
            digits_d[cursor_q] = (cur_digit == '0) ? cur_limit : cur_digit - 4'd1;
          end
        end else if (blink_cnt_q == CNT_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = !blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
      end

      CONV_MIN: begin
        set_minutes_d = conv_bin[MIN_W-1:0];
        state_d       = CONV_SEC;
      end

      CONV_SEC: begin
        set_seconds_d = conv_bin[SEC_W-1:0];
        state_d       = CONV_CS;
      end

      CONV_CS: begin
        set_m_seconds_d = conv_bin;
        set_valid_d     = 1'b1;
        state_d         = enable ? EDIT : IDLE;
        blink_cnt_d     = '0;
        blink_on_d      = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Display values are built from next-state so the registered outputs match the current state.
  always_comb begin
    editing_d = (state_d != IDLE);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (state_d == IDLE) begin
        bch_d[i] = BLANK_CODE;
      end else if ((state_d == EDIT) && !blink_on_d && (cursor_d == CURSOR_W'(i))) begin
        bch_d[i] = BLANK_CODE;
      end else begin
        bch_d[i] = digits_d[i];
      end
    end
  end

  always_ff @(posedge mili_clk) begin
    if (reset) begin
      state_q         <= IDLE;
      digits_q        <= '0;
      cursor_q        <= '0;
      blink_cnt_q     <= '0;
      blink_on_q      <= 1'b1;
      set_minutes_q   <= '0;
      set_seconds_q   <= '0;
      set_m_seconds_q <= '0;
      set_valid_q     <= 1'b0;
      editing_q       <= 1'b0;
      bch_q           <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      state_q         <= state_d;
      digits_q        <= digits_d;
      cursor_q        <= cursor_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_on_q      <= blink_on_d;
      set_minutes_q   <= set_minutes_d;
      set_seconds_q   <= set_seconds_d;
      set_m_seconds_q <= set_m_seconds_d;
      set_valid_q     <= set_valid_d;
      editing_q       <= editing_d;
      bch_q           <= bch_d;
    end
  end

  assign bch0          = bch_q[0];
  assign bch1          = bch_q[1];
  assign bch2          = bch_q[2];
  assign bch3          = bch_q[3];
  assign bch4          = bch_q[4];
  assign bch5          = bch_q[5];
  assign set_minutes   = set_minutes_q;
  assign set_seconds   = set_seconds_q;
  assign set_m_seconds = set_m_seconds_q;
  assign set_valid     = set_valid_q;
  assign editing       = editing_q;

endmodule

// File: tb/tb_time_digit_entry.sv
// Bench for time_digit_entry: directed scenarios plus a scoreboard of expected
// committed values that is checked whenever set_valid strobes.
module tb_time_digit_entry;

  logic       mili_clk   = 1'b0;
  logic       reset      = 1'b1;
  logic       enable     = 1'b0;
  logic       btn_next   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic       btn_dec    = 1'b0;
  logic       btn_commit = 1'b0;
  logic [3:0] bch0, bch1, bch2, bch3, bch4, bch5;
  logic [5:0] set_minutes, set_seconds;
  logic [6:0] set_m_seconds;
  logic       set_valid, editing;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int min;
    int sec;
    int cs;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  logic [3:0] bch [6];

  assign bch[0] = bch0;
  assign bch[1] = bch1;
  assign bch[2] = bch2;
  assign bch[3] = bch3;
  assign bch[4] = bch4;
  assign bch[5] = bch5;

  time_digit_entry #(
    .BLINK_HALF (4),
    .BLANK_CODE (4'd10)
  ) dut (
    .mili_clk      (mili_clk),
    .reset         (reset),
    .enable        (enable),
    .btn_next      (btn_next),
    .btn_inc       (btn_inc),
    .btn_dec       (btn_dec),
    .btn_commit    (btn_commit),
    .bch0          (bch0),
    .bch1          (bch1),
    .bch2          (bch2),
    .bch3          (bch3),
    .bch4          (bch4),
    .bch5          (bch5),
    .set_minutes   (set_minutes),
    .set_seconds   (set_seconds),
    .set_m_seconds (set_m_seconds),
    .set_valid     (set_valid),
    .editing       (editing)
  );

  always #5 mili_clk = ~mili_clk;

  always @(posedge mili_clk) cyc <= cyc + 1;

  // Every strobe must match the oldest pending commit, in value and in timing.
  always @(negedge mili_clk) begin
    if (set_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: set_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        got_e = sb.pop_front();
        checks += 3;
        if (got_e.due != cyc) begin
          errors++;
          $display("FAIL strobe_timing: strobe at cycle %0d, expected cycle %0d", cyc, got_e.due);
        end
        if (int'(set_minutes) != got_e.min) begin
          errors++;
          $display("FAIL sb_minutes: got %0d, expected %0d", set_minutes, got_e.min);
        end
        if (int'(set_seconds) != got_e.sec) begin
          errors++;
          $display("FAIL sb_seconds: got %0d, expected %0d", set_seconds, got_e.sec);
        end
        if (int'(set_m_seconds) != got_e.cs) begin
          errors++;
          $display("FAIL sb_m_seconds: got %0d, expected %0d", set_m_seconds, got_e.cs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge mili_clk);
    #1;
  endtask

  task automatic press(input logic n, input logic i, input logic d, input logic c);
    btn_next   = n;
    btn_inc    = i;
    btn_dec    = d;
    btn_commit = c;
    tick();
    btn_next   = 1'b0;
    btn_inc    = 1'b0;
    btn_dec    = 1'b0;
    btn_commit = 1'b0;
  endtask

  task automatic enter_edit();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bch[i] !== 4'd10) begin
        errors++;
        $display("FAIL reset_bch%0d: got %0d, expected 10", i, bch[i]);
      end
    end
    checks += 5;
    if (editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %b, expected 0", editing); end
    if (set_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", set_valid); end
    if (set_minutes !== 6'd0) begin errors++; $display("FAIL reset_minutes: got %0d, expected 0", set_minutes); end
    if (set_seconds !== 6'd0) begin errors++; $display("FAIL reset_seconds: got %0d, expected 0", set_seconds); end
    if (set_m_seconds !== 7'd0) begin errors++; $display("FAIL reset_m_seconds: got %0d, expected 0", set_m_seconds); end
    reset = 1'b0;
    tick();
    checks += 2;
    if (editing !== 1'b0) begin errors++; $display("FAIL idle_editing: got %b, expected 0", editing); end
    if (bch3 !== 4'd10) begin errors++; $display("FAIL idle_bch3: got %0d, expected 10", bch3); end
  endtask

  task automatic test_basic_entry();
    enable = 1'b1;
    tick();
    checks += 3;
    if (editing !== 1'b1) begin errors++; $display("FAIL edit_editing: got %b, expected 1", editing); end
    if (bch0 !== 4'd0) begin errors++; $display("FAIL edit_bch0: got %0d, expected 0", bch0); end
    if (bch5 !== 4'd0) begin errors++; $display("FAIL edit_bch5: got %0d, expected 0", bch5); end
    repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bch0 !== 4'd3) begin errors++; $display("FAIL basic_bch0: got %0d, expected 3", bch0); end
    sb.push_back('{37, 0, 0, cyc + 4});
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks += 3;
    if (editing !== 1'b1) begin errors++; $display("FAIL conv_editing: got %b, expected 1", editing); end
    if (bch0 !== 4'd3) begin errors++; $display("FAIL conv_bch0: got %0d, expected 3", bch0); end
    if (bch1 !== 4'd7) begin errors++; $display("FAIL conv_bch1: got %0d, expected 7", bch1); end
    repeat (3) tick();
    checks += 2;
    if (set_minutes !== 6'd37) begin errors++; $display("FAIL basic_hold_minutes: got %0d, expected 37", set_minutes); end
    if (set_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b, expected 0", set_valid); end
  endtask

  task automatic test_wrap();
    enter_edit();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (bch0 !== 4'd5) begin errors++; $display("FAIL wrap_dec_d0: got %0d, expected 5", bch0); end
    if (bch1 !== 4'd0) begin errors++; $display("FAIL wrap_dec_d1: got %0d, expected 0", bch1); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bch0 !== 4'd0) begin errors++; $display("FAIL wrap_inc_d0: got %0d, expected 0", bch0); end
    repeat (5) press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bch5 !== 4'd9) begin errors++; $display("FAIL wrap_d5_nine: got %0d, expected 9", bch5); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (bch5 !== 4'd0) begin errors++; $display("FAIL wrap_inc_d5: got %0d, expected 0", bch5); end
    if (bch4 !== 4'd0) begin errors++; $display("FAIL wrap_no_carry_d4: got %0d, expected 0", bch4); end
    repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 2;
    if (bch2 !== 4'd5) begin errors++; $display("FAIL wrap_dec_d2: got %0d, expected 5", bch2); end
    if (bch3 !== 4'd0) begin errors++; $display("FAIL wrap_no_borrow_d3: got %0d, expected 0", bch3); end
  endtask

  task automatic test_max();
    int vals [6] = '{5, 9, 5, 9, 9, 9};
    enter_edit();
    for (int d = 0; d < 6; d++) begin
      repeat (vals[d]) press(1'b0, 1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (int'(bch[i]) != vals[i]) begin
        errors++;
        $display("FAIL max_bch%0d: got %0d, expected %0d", i, bch[i], vals[i]);
      end
    end
    sb.push_back('{59, 59, 99, cyc + 4});
    press(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    checks += 3;
    if (set_minutes !== 6'd59) begin errors++; $display("FAIL max_minutes: got %0d, expected 59", set_minutes); end
    if (set_seconds !== 6'd59) begin errors++; $display("FAIL max_seconds: got %0d, expected 59", set_seconds); end
    if (set_m_seconds !== 7'd99) begin errors++; $display("FAIL max_m_seconds: got %0d, expected 99", set_m_seconds); end
  endtask

  task automatic test_priority();
    enter_edit();
    press(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bch0 !== 4'd0) begin errors++; $display("FAIL prio_next_inc_d0: got %0d, expected 0", bch0); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks += 2;
    if (bch1 !== 4'd1) begin errors++; $display("FAIL prio_cursor_d1: got %0d, expected 1", bch1); end
    if (bch0 !== 4'd0) begin errors++; $display("FAIL prio_cursor_d0: got %0d, expected 0", bch0); end
    sb.push_back('{1, 0, 0, cyc + 4});
    press(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    checks++;
    if (bch1 !== 4'd1) begin errors++; $display("FAIL prio_commit_inc_d1: got %0d, expected 1", bch1); end
    press(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bch1 !== 4'd2) begin errors++; $display("FAIL prio_inc_dec_d1: got %0d, expected 2", bch1); end
  endtask

  task automatic test_abort();
    enter_edit();
    repeat (2) press(1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bch[i] !== 4'd10) begin
        errors++;
        $display("FAIL abort_bch%0d: got %0d, expected 10", i, bch[i]);
      end
    end
    checks += 2;
    if (editing !== 1'b0) begin errors++; $display("FAIL abort_editing: got %b, expected 0", editing); end
    if (set_minutes !== 6'd1) begin errors++; $display("FAIL abort_minutes: got %0d, expected 1", set_minutes); end
    repeat (3) tick();
    enable = 1'b1;
    tick();
    repeat (4) press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (set_minutes !== 6'd40) begin errors++; $display("FAIL midconv_minutes: got %0d, expected 40", set_minutes); end
    reset = 1'b1;
    tick();
    checks += 4;
    if (set_minutes !== 6'd0) begin errors++; $display("FAIL midconv_reset_minutes: got %0d, expected 0", set_minutes); end
    if (editing !== 1'b0) begin errors++; $display("FAIL midconv_reset_editing: got %b, expected 0", editing); end
    if (set_valid !== 1'b0) begin errors++; $display("FAIL midconv_reset_valid: got %b, expected 0", set_valid); end
    if (bch0 !== 4'd10) begin errors++; $display("FAIL midconv_reset_bch0: got %0d, expected 10", bch0); end
    enable = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks += 2;
    if (set_minutes !== 6'd0) begin errors++; $display("FAIL after_reset_minutes: got %0d, expected 0", set_minutes); end
    if (bch4 !== 4'd10) begin errors++; $display("FAIL after_reset_bch4: got %0d, expected 10", bch4); end
  endtask

  task automatic test_blink();
    int n;
    logic [3:0] exp_v;
    enter_edit();
    n = 0;
    repeat (12) begin
      exp_v = (((n / 4) % 2) == 0) ? 4'd0 : 4'd10;
      checks += 2;
      if (bch0 !== exp_v) begin errors++; $display("FAIL blink_idle_n%0d: got %0d, expected %0d", n, bch0, exp_v); end
      if (bch1 !== 4'd0) begin errors++; $display("FAIL blink_other_n%0d: got %0d, expected 0", n, bch1); end
      tick();
      n++;
    end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    repeat (10) begin
      exp_v = (((n / 4) % 2) == 0) ? 4'd1 : 4'd10;
      checks++;
      if (bch0 !== exp_v) begin errors++; $display("FAIL blink_restart_n%0d: got %0d, expected %0d", n, bch0, exp_v); end
      tick();
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_wrap();
    test_max();
    test_priority();
    test_abort();
    test_blink();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_pending: got %0d commits without a strobe, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
